cp_insert_param: RTL



---
 rtl/cp_insert_param.sv | 102 ++++++++++
 1 files changed

// File: rtl/cp_insert_param.sv
// cp_insert_param: ping-pong buffered cyclic-prefix inserter with run-time CP length.
// Each NFFT-sample symbol is emitted as its last L samples followed by the whole symbol.
module cp_insert_param #(
  parameter int NFFT = 64,
  parameter int W = 16,
  localparam int AW = $clog2(NFFT)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                in_sop,
  input  logic                in_valid,
  input  logic signed [W-1:0] in_i,
  input  logic signed [W-1:0] in_q,
  output logic                in_ready,
  input  logic [1:0]          cp_mode,
  output logic signed [W-1:0] out_i,
  output logic signed [W-1:0] out_q,
  output logic                out_valid,
  output logic                sop_out
);
  typedef enum logic [1:0] {IDLE, CP, BODY} state_t;
  logic [2*W-1:0] r_mem [2*NFFT];
  logic [2*W-1:0] r_rd;
  logic [1:0] r_full;
  logic r_wbank, r_wactive, r_rbank, r_first, r_p_valid, r_p_sop;
  logic [AW-1:0] r_waddr, r_raddr;
  state_t r_state;
  logic w_wr, w_issue, w_last;
  logic [AW-1:0] w_wa, w_cp_start;
  assign in_ready = !r_full[r_wbank];
  assign w_wr = en && in_valid && in_ready && (in_sop || r_wactive);
  assign w_wa = in_sop ? '0 : r_waddr;
  assign w_issue = r_state != IDLE;
  assign w_last = r_raddr == AW'(NFFT - 1);
  assign w_cp_start = AW'(NFFT - (NFFT >> ({1'b0, cp_mode} + 3'd2)));
  // Banks never overlap: writes go only to a non-full bank, reads only from a full one.
  always_ff @(posedge clk)
    if (en) begin
      if (w_wr) r_mem[{r_wbank, w_wa}] <= {in_i, in_q};
      r_rd <= r_mem[{r_rbank, r_raddr}];
    end
  always_ff @(posedge clk)
    if (rst) begin
      r_full <= '0;
      r_wbank <= 1'b0;
      r_wactive <= 1'b0;
      r_waddr <= '0;
      r_rbank <= 1'b0;
      r_raddr <= '0;
      r_state <= IDLE;
      r_first <= 1'b0;
      r_p_valid <= 1'b0;
      r_p_sop <= 1'b0;
      out_i <= '0;
      out_q <= '0;
      out_valid <= 1'b0;
      sop_out <= 1'b0;
    end else if (en) begin
      if (w_wr) begin
        r_waddr <= w_wa + AW'(1);
        r_wactive <= w_wa != AW'(NFFT - 1);
        if (w_wa == AW'(NFFT - 1)) begin
          r_full[r_wbank] <= 1'b1;
          r_wbank <= !r_wbank;
        end
      end
      r_p_valid <= w_issue;
      r_p_sop <= r_first;
      r_first <= 1'b0;
      unique case (r_state)
        IDLE:
          if (r_full[r_rbank]) begin
            r_state <= CP;
            r_raddr <= w_cp_start;
            r_first <= 1'b1;
          end
        CP: begin
          r_raddr <= r_raddr + AW'(1);
          if (w_last) r_state <= BODY;
        end
        BODY: begin
          r_raddr <= r_raddr + AW'(1);
          // Release and chain straight into the other bank's prefix when it is ready.
          if (w_last) begin
            r_full[r_rbank] <= 1'b0;
            r_rbank <= !r_rbank;
            r_state <= r_full[!r_rbank] ? CP : IDLE;
            r_raddr <= w_cp_start;
            r_first <= r_full[!r_rbank];
          end
        end
        default: r_state <= IDLE;
      endcase
      if (r_p_valid) begin
        out_i <= r_rd[2*W-1:W];
        out_q <= r_rd[W-1:0];
      end
      out_valid <= r_p_valid;
      sop_out <= r_p_sop;
    end
endmodule
